noc_ring_input_unit: RTL
========================

# noc_ring_input_unit

Input stage of one ring-NoC router port (West, East or Local). It buffers incoming flits in a credit-managed FIFO and computes the output direction for each packet from the head-flit destination x. It holds that route until the tail flit, then presents flits with a one-hot `direction_t` to the downstream switch allocator/crossbar. The upstream neighbour's credit counter is replenished one credit per dequeued flit.

## Interface
- `FlitWidth`, 34: flit width. `[FlitWidth-1:FlitWidth-2]` is `preamble_t` {head, tail}.
  - Head flit only: `[FlitWidth-3 -: xWidth]` source x, next `xWidth` bits destination x, next `messageTypeWidth` bits `message_t`, remainder payload.
- `Depth`, 4: FIFO entries; power of two, ≥2.
- `PortsEnabled`, `noc::AllPorts`: 3-bit {local, east, west} enable mask of this router.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `local_x  in  xWidth`: this router's x coordinate; static after reset.
- `data_in  in  FlitWidth`: incoming flit.
- `data_in_valid  in  1`: flit write strobe, one flit per cycle.
- `credit_out  out  1`: one-cycle pulse per freed entry, to upstream.
- `data_out  out  FlitWidth`: flit at FIFO head.
- `data_out_valid  out  1`: `data_out` / `data_out_dir` are valid.
- `data_out_dir  out  3`: `direction_t` one-hot route of the current flit.
- `data_out_ready  in  1`: allocator accepts the flit; transfer = valid & ready.
- `occupancy  out  $clog2(Depth)+1`: stored flit count.
- `err_overflow  out  1`: sticky; write arrived while full.
- `err_protocol  out  1`: sticky; preamble sequence violation.
- `err_route  out  1`: sticky; computed direction is disabled in `PortsEnabled`.

## Operation
- FIFO: circular buffer with read/write pointers plus count.
  - Write when `data_in_valid` & not full.
  - Write when full is dropped and sets `err_overflow`. Fullness is evaluated before a same-cycle read, so a write is dropped even if a read frees an entry that cycle.
  - Simultaneous read and write on a non-full FIFO leaves `occupancy` unchanged. Pointers wrap modulo `Depth`.
- Route function, with dx = destination x from the head flit:
  - dx > `local_x` → `goEast`
  - dx < `local_x` → `goWest`
  - dx == `local_x` → `goLocal`
  - If the result's bit is 0 in `PortsEnabled`, output `goLocal` instead and set `err_route`.
- FSM `IDLE` / `IN_PACKET`:
  - **IDLE**, FIFO head has head=1: `data_out_valid`=1; `data_out_dir` = route function, combinational from the FIFO head.
    - On transfer with tail=0: latch the route into `route_q`, go to IN_PACKET.
    - On transfer with tail=1 (single-flit packet): stay in IDLE.
  - **IDLE**, FIFO head has head=0: the flit is discarded internally. It is dequeued with `data_out_valid`=0, `credit_out` is pulsed, and `err_protocol` is set. One orphan flit is discarded per cycle.
  - **IN_PACKET**: `data_out_dir` = `route_q`; `data_out_valid` = FIFO non-empty.
    - On transfer of a tail=1 flit: go to IDLE.
    - A head=1 flit at the FIFO head sets `err_protocol`. It is then treated as a new packet: the route is recomputed combinationally, and `route_q` is reloaded on its transfer.
- `credit_out` pulses once for every dequeue, whether forwarded or discarded. It never pulses for dropped writes.
- Sticky error flags clear only on reset.

## Timing
- Reset (async assert, sync-released use): FIFO empty, pointers 0, state IDLE, `route_q`=0.
  - `credit_out`=0, `data_out_valid`=0, `data_out`=0, `data_out_dir`=0, `occupancy`=0, all error flags 0.
- A reset asserted mid-packet discards all stored flits and issues no credits. Upstream credit counters must be reset together with this block.
- Latency from write to `data_out_valid`: 1 cycle. A flit written at edge N is visible after edge N; there is no bypass.
- Throughput: 1 flit/cycle with `data_out_ready` held high.
- `credit_out` is registered: it is high in the cycle after the dequeue edge.
- `data_out_valid` never depends combinationally on `data_out_ready`. While valid & !ready, `data_out` and `data_out_dir` hold stable.
- `occupancy` is registered and reflects the state after the last edge.

## Test plan
- Single-flit packet {head=1,tail=1}, dest x=5, `local_x`=2 → `data_out_dir`=3'b010 (east), valid 1 cycle after write, `credit_out` 1 cycle after transfer, state stays IDLE.
- 4-flit packet dest x=0, `local_x`=3, `data_out_ready` toggling 1,0,0,1,… → all 4 flits leave in order with dir=3'b001 (west) held, 4 credit pulses total, FSM returns to IDLE after the tail transfer.
- Dest x=4 == `local_x` → dir=3'b100; with `PortsEnabled`=3'b101 and dest x=6 > `local_x`=4 → dir=3'b100 and `err_route`=1.
- `data_out_ready`=0, 5 consecutive writes with `Depth`=4 → `occupancy`=4, 5th write dropped, `err_overflow`=1, then drain yields exactly the first 4 flits.
- Body flit (head=0) in IDLE → never valid at output, one `credit_out` pulse, `err_protocol`=1. Head flit arriving mid-packet → `err_protocol`=1 and the new route is used.
- Assert `rst`=0 asynchronously with 3 flits buffered → `occupancy`=0, `data_out_valid`=0 immediately, no credit pulses, errors cleared.

Source files
------------

// File: rtl/noc_ring_input_unit.sv
// Ring-NoC router input port: credit-managed flit FIFO plus per-packet route
// computation, with the route held from the head flit through the tail flit.
module noc_ring_input_unit #(
    parameter int unsigned FlitWidth    = 34,
    parameter int unsigned XWidth       = 4,
    parameter int unsigned Depth        = 4,
    parameter logic [2:0]  PortsEnabled = 3'b111
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XWidth-1:0]        local_x,
    input  logic [FlitWidth-1:0]     data_in,
    input  logic                     data_in_valid,
    output logic                     credit_out,
    output logic [FlitWidth-1:0]     data_out,
    output logic                     data_out_valid,
    output logic [2:0]               data_out_dir,
    input  logic                     data_out_ready,
    output logic [$clog2(Depth):0]   occupancy,
    output logic                     err_overflow,
    output logic                     err_protocol,
    output logic                     err_route
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] GoWest  = 3'b001;
    localparam logic [2:0] GoEast  = 3'b010;
    localparam logic [2:0] GoLocal = 3'b100;

    typedef enum logic {StIdle, StInPacket} state_e;

    logic [FlitWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]      count_q;
    state_e               state_q;
    logic [2:0]           route_q;
    logic                 credit_q;
    logic                 err_overflow_q, err_protocol_q, err_route_q;

    logic [FlitWidth-1:0] head_flit;
    logic [XWidth-1:0]    dest_x;
    logic                 empty, full, is_head, is_tail;
    logic                 out_valid, discard, xfer, deq, wr;
    logic [2:0]           route_raw, route_calc, dir;
    logic                 route_bad;

    assign head_flit = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(Depth));
    assign is_head   = !empty && head_flit[FlitWidth-1];
    assign is_tail   = head_flit[FlitWidth-2];
    // Destination x sits directly below the source x field.
    assign dest_x    = head_flit[FlitWidth-3-XWidth -: XWidth];

    always_comb begin
        route_raw = GoLocal;
        if (dest_x > local_x) begin
            route_raw = GoEast;
        end else if (dest_x < local_x) begin
            route_raw = GoWest;
        end
        route_bad  = ((route_raw & PortsEnabled) == 3'b000);
        route_calc = route_bad ? GoLocal : route_raw;
    end

    // Orphan body flits in IDLE are dropped internally but still return a credit.
    assign out_valid = !empty && ((state_q == StInPacket) || head_flit[FlitWidth-1]);
    assign discard   = !empty && (state_q == StIdle) && !head_flit[FlitWidth-1];
    assign xfer      = out_valid && data_out_ready;
    assign deq       = xfer || discard;
    assign wr        = data_in_valid && !full;

    always_comb begin
        dir = 3'b000;
        if (is_head) begin
            dir = route_calc;
        end else if (state_q == StInPacket) begin
            dir = route_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= StIdle;
            route_q        <= 3'b000;
            credit_q       <= 1'b0;
            err_overflow_q <= 1'b0;
            err_protocol_q <= 1'b0;
            err_route_q    <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q  <= count_q + CntW'(wr) - CntW'(deq);
            credit_q <= deq;

            if (data_in_valid && full) begin
                err_overflow_q <= 1'b1;
            end
            if (discard || ((state_q == StInPacket) && is_head)) begin
                err_protocol_q <= 1'b1;
            end
            if (is_head && route_bad) begin
                err_route_q <= 1'b1;
            end

            if (xfer) begin
                if (is_head) begin
                    route_q <= route_calc;
                end
                state_q <= is_tail ? StIdle : StInPacket;
            end
        end
    end

    assign credit_out     = credit_q;
    assign data_out       = out_valid ? head_flit : '0;
    assign data_out_valid = out_valid;
    assign data_out_dir   = dir;
    assign occupancy      = count_q;
    assign err_overflow   = err_overflow_q;
    assign err_protocol   = err_protocol_q;
    assign err_route      = err_route_q;

endmodule
